// File: rtl/bus_slice_pkg.sv
// Shared types and slice-range helpers for the bus slice assembler.
// The mask helpers are width-agnostic so a future splitter can reuse them.
package bus_slice_pkg;

    localparam int MAXW = 32;

    typedef enum logic {
        COLLECT,
        EMIT
    } state_t;

    function automatic logic [MAXW-1:0] slice_mask(
        input int msb,
        input int lsb,
        input int width
    );
        logic [MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < MAXW; i++) begin
            m[i] = (i >= lsb) && (i <= msb) && (i < width);
        end
        return m;
    endfunction

    function automatic logic range_ok(
        input int msb,
        input int lsb,
        input int width
    );
        return (msb >= lsb) && (msb < width);
    endfunction

endpackage

// File: rtl/bus_slice_mask_gen.sv
// Turns a [msb:lsb] slice descriptor into a bus-wide bit mask plus
// a legality flag; purely combinational.
module bus_slice_mask_gen
    import bus_slice_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH) + 1
) (
    input  logic [IDXW-1:0]  i_msb,
    input  logic [IDXW-1:0]  i_lsb,
    output logic [WIDTH-1:0] o_smask,
    output logic             o_range_ok
);

    assign o_smask = WIDTH'(slice_mask(int'(i_msb), int'(i_lsb), WIDTH));
    assign o_range_ok = range_ok(int'(i_msb), int'(i_lsb), WIDTH);

endmodule

// File: rtl/bus_slice_assembler.sv
// Collects shuffled bit slices of one bus word and emits the word once
// every bit has been written exactly once.
module bus_slice_assembler
    import bus_slice_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDXW-1:0]  in_msb,
    input  logic [IDXW-1:0]  in_lsb,
    input  logic [WIDTH-1:0] in_data,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_bus,
    output logic             err_overlap,
    output logic             err_range
);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_bus;
    logic             r_err_overlap;
    logic             r_err_range;

    logic [WIDTH-1:0] w_smask;
    logic             w_range_ok;
    logic             w_acc;
    logic             w_overlap;
    logic             w_write;
    logic [WIDTH-1:0] w_mask_new;
    logic [WIDTH-1:0] w_bus_new;

    bus_slice_mask_gen #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_mask_gen (
        .i_msb      (in_msb),
        .i_lsb      (in_lsb),
        .o_smask    (w_smask),
        .o_range_ok (w_range_ok)
    );

    assign in_ready    = (r_state == COLLECT);
    assign out_valid   = (r_state == EMIT);
    assign out_bus     = r_bus;
    assign err_overlap = r_err_overlap;
    assign err_range   = r_err_range;

    // abort wins over a same-cycle slice, which is then silently dropped
    assign w_acc      = in_valid && in_ready && !abort;
    assign w_overlap  = |(r_mask & w_smask);
    assign w_write    = w_acc && w_range_ok && !w_overlap;
    assign w_mask_new = r_mask | w_smask;
    assign w_bus_new  = (r_bus & ~w_smask) | ((in_data << in_lsb) & w_smask);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            COLLECT: begin
                if (w_write && (&w_mask_new)) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    w_next_state = COLLECT;
                end
            end
            default: w_next_state = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= COLLECT;
            r_mask        <= '0;
            r_bus         <= '0;
            r_err_overlap <= 1'b0;
            r_err_range   <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_err_overlap <= w_acc && w_range_ok && w_overlap;
            r_err_range   <= w_acc && !w_range_ok;
            if (r_state == COLLECT) begin
                if (abort) begin
                    r_mask <= '0;
                end else if (w_write) begin
                    r_mask <= w_mask_new;
                    r_bus  <= w_bus_new;
                end
            end else if (out_ready) begin
                r_mask <= '0;
            end
        end
    end

endmodule

// File: tb/tb_bus_slice_assembler.sv
// Directed checks of slice reassembly, error pulses, stall, reset and abort
// for a 4-bit bus.
module tb_bus_slice_assembler;

    localparam int WIDTH = 4;
    localparam int IDXW  = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [IDXW-1:0]  in_msb;
    logic [IDXW-1:0]  in_lsb;
    logic [WIDTH-1:0] in_data;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_bus;
    logic             err_overlap;
    logic             err_range;

    int total;
    int bad;

    bus_slice_assembler #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_msb      (in_msb),
        .in_lsb      (in_lsb),
        .in_data     (in_data),
        .abort       (abort),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bus     (out_bus),
        .err_overlap (err_overlap),
        .err_range   (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic slice(input int msb, input int lsb, input int data);
        in_valid = 1'b1;
        in_msb   = IDXW'(msb);
        in_lsb   = IDXW'(lsb);
        in_data  = WIDTH'(data);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_msb    = '0;
        in_lsb    = '0;
        in_data   = '0;
        abort     = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_bus", 32'(out_bus), 0);
        chk("rst_errs", 32'({err_overlap, err_range}), 0);

        // three slices back-to-back
        slice(3, 3, 1);
        chk("t1_mid_valid", 32'(out_valid), 0);
        slice(2, 1, 2);
        slice(0, 0, 1);
        chk("t1_valid", 32'(out_valid), 1);
        chk("t1_bus", 32'(out_bus), 32'hD);
        chk("t1_in_ready", 32'(in_ready), 0);
        chk("t1_errs", 32'({err_overlap, err_range}), 0);
        step();
        chk("t1_done_valid", 32'(out_valid), 0);
        chk("t1_done_ready", 32'(in_ready), 1);

        // overlap
        slice(3, 2, 3);
        slice(2, 2, 0);
        chk("t2_ovl", 32'(err_overlap), 1);
        chk("t2_ovl_ready", 32'(in_ready), 1);
        slice(1, 0, 0);
        chk("t2_ovl_pulse", 32'(err_overlap), 0);
        chk("t2_valid", 32'(out_valid), 1);
        chk("t2_bus", 32'(out_bus), 32'hC);
        step();

        // bad ranges
        slice(1, 2, 3);
        chk("t3_rng_a", 32'(err_range), 1);
        chk("t3_ready_a", 32'(in_ready), 1);
        slice(4, 4, 1);
        chk("t3_rng_b", 32'(err_range), 1);
        chk("t3_ready_b", 32'(in_ready), 1);
        chk("t3_valid", 32'(out_valid), 0);
        step();
        chk("t3_rng_clr", 32'(err_range), 0);
        slice(3, 0, 5);
        chk("t3_full_valid", 32'(out_valid), 1);
        chk("t3_full_bus", 32'(out_bus), 32'h5);
        chk("t3_no_ovl", 32'(err_overlap), 0);
        step();

        // stalled consumer; offered slice and abort must be ignored
        out_ready = 1'b0;
        slice(3, 0, 9);
        in_valid = 1'b1;
        in_msb   = 3'd3;
        in_lsb   = 3'd0;
        in_data  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            abort = (i == 1);
            chk("t4_valid", 32'(out_valid), 1);
            chk("t4_ready", 32'(in_ready), 0);
            chk("t4_bus", 32'(out_bus), 32'h9);
            step();
        end
        abort = 1'b0;
        in_valid = 1'b0;
        chk("t4_held_bus", 32'(out_bus), 32'h9);
        chk("t4_held_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        chk("t4_rel_valid", 32'(out_valid), 0);
        chk("t4_rel_ready", 32'(in_ready), 1);
        chk("t4_errs", 32'({err_overlap, err_range}), 0);

        // reset mid-word
        slice(3, 2, 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_rst_bus", 32'(out_bus), 0);
        chk("t5_rst_ready", 32'(in_ready), 1);
        slice(1, 0, 2);
        chk("t5_partial", 32'(out_valid), 0);
        slice(3, 2, 1);
        chk("t5_valid", 32'(out_valid), 1);
        chk("t5_bus", 32'(out_bus), 32'h6);
        step();

        // single full slice, then abort with a slice
        slice(3, 0, 32'hA);
        chk("t6_valid", 32'(out_valid), 1);
        chk("t6_bus", 32'(out_bus), 32'hA);
        step();
        slice(3, 2, 3);
        abort = 1'b1;
        slice(1, 0, 0);
        abort = 1'b0;
        chk("t6_abort_valid", 32'(out_valid), 0);
        chk("t6_abort_errs", 32'({err_overlap, err_range}), 0);
        slice(0, 0, 32'hE);
        chk("t6_after_ovl", 32'(err_overlap), 0);
        slice(3, 1, 3);
        chk("t6_last_valid", 32'(out_valid), 1);
        chk("t6_last_bus", 32'(out_bus), 32'h6);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
